mlp_layer_engine: RTL and testbench

- Time-multiplexed, parametrised fully-connected inference engine for binary-activation, ternary-weight MLPs.
- Successor to the fixed three-layer calculator path, which fed a hard-wired 1024/64/10 network. This block supports a configurable count of identical hidden layers, a configurable lane count per cycle, and configurable memory read latency.
- It accepts one input vector over a valid/ready handshake and fetches one weight row plus bias per neuron from external memory.
- It returns the argmax class and its score over a valid/ready handshake. It sits between the window slider and downstream result logic.

---
 rtl/neuralcore_pkg.sv | 36 +++
 rtl/mlp_layer_engine_if.sv | 34 +++
 rtl/ternary_dot_lane.sv | 20 ++
 rtl/mlp_layer_engine.sv | 189 ++++++++++++++++++
 tb/tb_mlp_layer_engine.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuralcore_pkg.sv
// Shared types and helpers for the binary-activation / ternary-weight MLP engine.
package neuralcore_pkg;

    localparam logic [1:0] TW_ZERO = 2'b00;
    localparam logic [1:0] TW_POS  = 2'b01;
    localparam logic [1:0] TW_NEG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ACCUM,
        COMMIT,
        DONE
    } engine_state_e;

    // Weight x activation, where activation 1 means +1 and 0 means -1; 2'b10 is also zero.
    function automatic logic signed [1:0] ternary_mul(input logic [1:0] w, input logic a);
        logic signed [1:0] r;
        r = 2'sd0;
        if (w == TW_POS) begin
            r = a ? 2'sd1 : -2'sd1;
        end else if (w == TW_NEG) begin
            r = a ? -2'sd1 : 2'sd1;
        end
        return r;
    endfunction

    // Signed score width: holds +/-fan-in plus any bias without overflow.
    function automatic int unsigned score_width(input int unsigned in_width, input int unsigned bias_w);
        int unsigned a;
        a = 32'($clog2(in_width)) + 32'd2;
        return ((a > bias_w) ? a : bias_w) + 32'd1;
    endfunction

endpackage

// File: rtl/mlp_layer_engine_if.sv
// Input-vector, weight-memory and result handshakes of the MLP engine.
interface mlp_layer_engine_if #(
    parameter int unsigned IN_WIDTH    = 256,
    parameter int unsigned BIAS_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned NUM_CLASSES = 10
);
    localparam int unsigned SCORE_W = neuralcore_pkg::score_width(IN_WIDTH, BIAS_W);
    localparam int unsigned CLASS_W = $clog2(NUM_CLASSES);

    logic                        in_valid;
    logic                        in_ready;
    logic [IN_WIDTH-1:0]         in_data;
    logic                        w_ren;
    logic [ADDR_W-1:0]           w_addr;
    logic [2*IN_WIDTH-1:0]       w_data;
    logic signed [BIAS_W-1:0]    b_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [CLASS_W-1:0]          out_class;
    logic signed [SCORE_W-1:0]   out_score;
    logic                        busy;

    modport slave (
        input  in_valid, in_data, w_data, b_data, out_ready,
        output in_ready, w_ren, w_addr, out_valid, out_class, out_score, busy
    );

    modport master (
        output in_valid, in_data, w_data, b_data, out_ready,
        input  in_ready, w_ren, w_addr, out_valid, out_class, out_score, busy
    );

endinterface

// File: rtl/ternary_dot_lane.sv
// Combinational LANES-term signed partial sum of ternary weights against binary activations.
module ternary_dot_lane
    import neuralcore_pkg::*;
#(
    parameter int unsigned LANES  = 32,
    parameter int unsigned PSUM_W = $clog2(LANES) + 2
) (
    input  logic [2*LANES-1:0]       weights,
    input  logic [LANES-1:0]         acts,
    output logic signed [PSUM_W-1:0] psum_c
);

    always_comb begin
        psum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            psum_c = psum_c + PSUM_W'(ternary_mul(weights[2*i +: 2], acts[i]));
        end
    end

endmodule

// File: rtl/mlp_layer_engine.sv
// Time-multiplexed fully-connected inference engine: one neuron at a time, LANES terms per cycle,
// hidden layers produce sign activations and the output layer reports the argmax class.
module mlp_layer_engine
    import neuralcore_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = 256,
    parameter int unsigned HID_WIDTH   = 64,
    parameter int unsigned NUM_HIDDEN  = 2,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned LANES       = 32,
    parameter int unsigned BIAS_W      = 8,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    mlp_layer_engine_if.slave  bus
);

    localparam int unsigned SCORE_W    = score_width(IN_WIDTH, BIAS_W);
    localparam int unsigned CLASS_W    = $clog2(NUM_CLASSES);
    localparam int unsigned PSUM_W     = $clog2(LANES) + 2;
    localparam int unsigned IN_CHUNKS  = (IN_WIDTH + LANES - 1) / LANES;
    localparam int unsigned HID_CHUNKS = (HID_WIDTH + LANES - 1) / LANES;
    localparam int unsigned CHUNK_W    = $clog2(IN_CHUNKS + 1);
    localparam int unsigned WAIT_W     = $clog2(MEM_LATENCY + 1);
    localparam int unsigned MAX_N      = (HID_WIDTH > NUM_CLASSES) ? HID_WIDTH : NUM_CLASSES;
    localparam int unsigned NEUR_W     = $clog2(MAX_N + 1);
    localparam int unsigned LAYER_W    = $clog2(NUM_HIDDEN + 1);
    // Later layers only have HID_WIDTH inputs; terms above that must contribute nothing.
    localparam logic [2*IN_WIDTH-1:0] HID_MASK = (2*IN_WIDTH)'({(2*HID_WIDTH){1'b1}});

    engine_state_e             state;
    logic [IN_WIDTH-1:0]       act_cur;
    logic [HID_WIDTH-1:0]      act_nxt;
    logic [HID_WIDTH-1:0]      act_nxt_c;
    logic [2*IN_WIDTH-1:0]     w_row;
    logic signed [BIAS_W-1:0]  bias;
    logic signed [SCORE_W-1:0] acc;
    logic signed [SCORE_W-1:0] best_score;
    logic signed [SCORE_W-1:0] sum_c;
    logic [CLASS_W-1:0]        best_class;
    logic [CHUNK_W-1:0]        chunk;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [NEUR_W-1:0]         neuron;
    logic [LAYER_W-1:0]        layer;
    logic [2*LANES-1:0]        w_slice_c;
    logic [LANES-1:0]          a_slice_c;
    logic signed [PSUM_W-1:0]  psum_c;
    logic                      out_layer_c;
    logic                      last_neuron_c;
    logic                      last_chunk_c;
    logic                      take_c;

    ternary_dot_lane #(
        .LANES  (LANES),
        .PSUM_W (PSUM_W)
    ) u_dot (
        .weights (w_slice_c),
        .acts    (a_slice_c),
        .psum_c  (psum_c)
    );

    // Chunk mux, layer bookkeeping and the neuron's final score.
    always_comb begin
        w_slice_c = '0;
        a_slice_c = '0;
        for (int unsigned c = 0; c < IN_CHUNKS; c++) begin
            if (32'(chunk) == c) begin
                w_slice_c = w_row[c*2*LANES +: 2*LANES];
                a_slice_c = act_cur[c*LANES +: LANES];
            end
        end
        out_layer_c   = (32'(layer) == NUM_HIDDEN);
        last_neuron_c = out_layer_c ? (32'(neuron) == NUM_CLASSES - 1)
                                    : (32'(neuron) == HID_WIDTH - 1);
        last_chunk_c  = (32'(chunk) == ((layer == '0) ? IN_CHUNKS : HID_CHUNKS) - 1);
        sum_c         = acc + SCORE_W'(bias);
        take_c        = (neuron == '0) || (sum_c > best_score);
        act_nxt_c     = act_nxt;
        for (int unsigned n = 0; n < HID_WIDTH; n++) begin
            if (32'(neuron) == n) begin
                act_nxt_c[n] = ~sum_c[SCORE_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.w_ren     <= 1'b0;
            bus.w_addr    <= '0;
            bus.out_class <= '0;
            bus.out_score <= '0;
            bus.busy      <= 1'b0;
            act_cur       <= '0;
            act_nxt       <= '0;
            w_row         <= '0;
            bias          <= '0;
            acc           <= '0;
            best_score    <= '0;
            best_class    <= '0;
            chunk         <= '0;
            wait_cnt      <= '0;
            neuron        <= '0;
            layer         <= '0;
        end else begin
            bus.w_ren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        act_cur      <= bus.in_data;
                        neuron       <= '0;
                        layer        <= '0;
                        bus.w_addr   <= '0;
                        bus.w_ren    <= 1'b1;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (32'(wait_cnt) == MEM_LATENCY - 1) begin
                        w_row <= (layer == '0) ? bus.w_data : (bus.w_data & HID_MASK);
                        bias  <= bus.b_data;
                        acc   <= '0;
                        chunk <= '0;
                        state <= ACCUM;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ACCUM: begin
                    acc   <= acc + SCORE_W'(psum_c);
                    chunk <= chunk + CHUNK_W'(1);
                    if (last_chunk_c) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (out_layer_c) begin
                        if (take_c) begin
                            best_score <= sum_c;
                            best_class <= CLASS_W'(neuron);
                        end
                    end else begin
                        act_nxt <= act_nxt_c;
                        // Layer swap folds into the last neuron's commit.
                        if (last_neuron_c) begin
                            act_cur <= IN_WIDTH'(act_nxt_c);
                        end
                    end
                    if (out_layer_c && last_neuron_c) begin
                        bus.out_valid <= 1'b1;
                        bus.out_class <= take_c ? CLASS_W'(neuron) : best_class;
                        bus.out_score <= take_c ? sum_c : best_score;
                        state         <= DONE;
                    end else begin
                        bus.w_ren  <= 1'b1;
                        bus.w_addr <= bus.w_addr + ADDR_W'(1);
                        state      <= FETCH;
                        if (last_neuron_c) begin
                            neuron <= '0;
                            layer  <= layer + LAYER_W'(1);
                        end else begin
                            neuron <= neuron + NEUR_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Bench: two engine configurations share stimulus and weight tables; results are compared
// against a plain-arithmetic network model and a latency formula.
module tb_mlp_layer_engine;
    import neuralcore_pkg::*;

    localparam int unsigned IN_WIDTH    = 8;
    localparam int unsigned HID_WIDTH   = 4;
    localparam int unsigned NUM_HIDDEN  = 1;
    localparam int unsigned NUM_CLASSES = 2;
    localparam int unsigned BIAS_W      = 8;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned NUM_NEURONS = NUM_HIDDEN * HID_WIDTH + NUM_CLASSES;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic [2*IN_WIDTH-1:0]    w_mem [NUM_NEURONS];
    logic signed [BIAS_W-1:0] b_mem [NUM_NEURONS];
    logic [ADDR_W-1:0] pipe_a;
    logic [ADDR_W-1:0] pipe_b [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mlp_layer_engine_if #(.IN_WIDTH(IN_WIDTH), .BIAS_W(BIAS_W), .ADDR_W(ADDR_W),
                          .NUM_CLASSES(NUM_CLASSES)) bus_a ();
    mlp_layer_engine_if #(.IN_WIDTH(IN_WIDTH), .BIAS_W(BIAS_W), .ADDR_W(ADDR_W),
                          .NUM_CLASSES(NUM_CLASSES)) bus_b ();

    mlp_layer_engine #(.IN_WIDTH(IN_WIDTH), .HID_WIDTH(HID_WIDTH), .NUM_HIDDEN(NUM_HIDDEN),
                       .NUM_CLASSES(NUM_CLASSES), .LANES(4), .BIAS_W(BIAS_W),
                       .MEM_LATENCY(1), .ADDR_W(ADDR_W))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    mlp_layer_engine #(.IN_WIDTH(IN_WIDTH), .HID_WIDTH(HID_WIDTH), .NUM_HIDDEN(NUM_HIDDEN),
                       .NUM_CLASSES(NUM_CLASSES), .LANES(8), .BIAS_W(BIAS_W),
                       .MEM_LATENCY(3), .ADDR_W(ADDR_W))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    // Memories with 1- and 3-cycle read latency from the address bus.
    always @(posedge clk) begin
        pipe_a    <= bus_a.w_addr;
        pipe_b[0] <= bus_b.w_addr;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    always_comb begin
        bus_a.w_data = '0;
        bus_a.b_data = '0;
        bus_b.w_data = '0;
        bus_b.b_data = '0;
        if (int'(pipe_a) < NUM_NEURONS) begin
            bus_a.w_data = w_mem[int'(pipe_a)];
            bus_a.b_data = b_mem[int'(pipe_a)];
        end
        if (int'(pipe_b[2]) < NUM_NEURONS) begin
            bus_b.w_data = w_mem[int'(pipe_b[2])];
            bus_b.b_data = b_mem[int'(pipe_b[2])];
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tval(input logic [1:0] w, input int a);
        if (w == 2'b01) return a;
        if (w == 2'b11) return -a;
        return 0;
    endfunction

    task automatic model(input logic [IN_WIDTH-1:0] x, output int cls, output int score);
        int act [IN_WIDTH];
        int nxt [IN_WIDTH];
        int fan;
        int s;
        int base;
        foreach (act[i]) act[i] = x[i] ? 1 : -1;
        fan = IN_WIDTH;
        for (int k = 0; k < NUM_HIDDEN; k++) begin
            for (int n = 0; n < HID_WIDTH; n++) begin
                base = k * HID_WIDTH + n;
                s = int'(b_mem[base]);
                for (int i = 0; i < fan; i++) s += tval(w_mem[base][2*i +: 2], act[i]);
                nxt[n] = (s >= 0) ? 1 : -1;
            end
            for (int n = 0; n < HID_WIDTH; n++) act[n] = nxt[n];
            fan = HID_WIDTH;
        end
        cls = 0;
        score = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            base = NUM_HIDDEN * HID_WIDTH + c;
            s = int'(b_mem[base]);
            for (int i = 0; i < fan; i++) s += tval(w_mem[base][2*i +: 2], act[i]);
            if (c == 0 || s > score) begin
                cls = c;
                score = s;
            end
        end
    endtask

    function automatic int exp_lat(input int lanes, input int lat);
        int t;
        int fan;
        int cnt;
        t = 1;
        fan = IN_WIDTH;
        for (int k = 0; k <= NUM_HIDDEN; k++) begin
            cnt = (k < NUM_HIDDEN) ? HID_WIDTH : NUM_CLASSES;
            t += cnt * (2 + lat + (fan + lanes - 1) / lanes);
            fan = HID_WIDTH;
        end
        return t;
    endfunction

    task automatic run(input string tag, input logic [IN_WIDTH-1:0] x, input bit hold);
        int cls_m;
        int score_m;
        int lat_a = -1;
        int lat_b = -1;
        int ren_a = 0;
        int ren_b = 0;
        bit addr_ok_a = 1'b1;
        bit addr_ok_b = 1'b1;
        logic signed [31:0] cls_a, sc_a, cls_b, sc_b;
        model(x, cls_m, score_m);
        @(negedge clk);
        chk({tag, "_a_in_ready"}, bus_a.in_ready, 1);
        chk({tag, "_b_in_ready"}, bus_b.in_ready, 1);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = !hold;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = IN_WIDTH'($urandom);
        for (int n = 1; n < 200 && (lat_a < 0 || lat_b < 0); n++) begin
            if (n > 1) @(negedge clk);
            if (lat_a < 0 && bus_a.out_valid === 1'b1) begin
                lat_a = n; cls_a = bus_a.out_class; sc_a = $signed(bus_a.out_score);
            end
            if (lat_b < 0 && bus_b.out_valid === 1'b1) begin
                lat_b = n; cls_b = bus_b.out_class; sc_b = $signed(bus_b.out_score);
            end
            if (bus_a.w_ren === 1'b1) begin
                if (int'(bus_a.w_addr) != ren_a) addr_ok_a = 1'b0;
                ren_a++;
            end
            if (bus_b.w_ren === 1'b1) begin
                if (int'(bus_b.w_addr) != ren_b) addr_ok_b = 1'b0;
                ren_b++;
            end
        end
        chk({tag, "_a_latency"}, lat_a, exp_lat(4, 1));
        chk({tag, "_b_latency"}, lat_b, exp_lat(8, 3));
        chk({tag, "_a_class"}, cls_a, cls_m);
        chk({tag, "_a_score"}, sc_a, score_m);
        chk({tag, "_b_class"}, cls_b, cls_m);
        chk({tag, "_b_score"}, sc_b, score_m);
        chk({tag, "_a_reads"}, ren_a, NUM_NEURONS);
        chk({tag, "_b_reads"}, ren_b, NUM_NEURONS);
        chk({tag, "_a_addr_seq"}, addr_ok_a, 1);
        chk({tag, "_b_addr_seq"}, addr_ok_b, 1);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk({tag, "_hold_a_valid"}, bus_a.out_valid, 1);
                chk({tag, "_hold_a_class"}, bus_a.out_class, cls_m);
                chk({tag, "_hold_a_score"}, $signed(bus_a.out_score), score_m);
                chk({tag, "_hold_a_in_ready"}, bus_a.in_ready, 0);
                chk({tag, "_hold_b_valid"}, bus_b.out_valid, 1);
                chk({tag, "_hold_b_in_ready"}, bus_b.in_ready, 0);
                in_valid = 1'b1;
                in_data  = ~x;
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_release_a_in_ready"}, bus_a.in_ready, 1);
            chk({tag, "_release_a_valid"}, bus_a.out_valid, 0);
            chk({tag, "_release_b_in_ready"}, bus_b.in_ready, 1);
            chk({tag, "_release_b_valid"}, bus_b.out_valid, 0);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_a_in_ready"}, bus_a.in_ready, 1);
        chk({tag, "_a_out_valid"}, bus_a.out_valid, 0);
        chk({tag, "_a_w_ren"}, bus_a.w_ren, 0);
        chk({tag, "_a_busy"}, bus_a.busy, 0);
        chk({tag, "_a_class"}, bus_a.out_class, 0);
        chk({tag, "_a_score"}, $signed(bus_a.out_score), 0);
        chk({tag, "_b_in_ready"}, bus_b.in_ready, 1);
        chk({tag, "_b_out_valid"}, bus_b.out_valid, 0);
        chk({tag, "_b_w_ren"}, bus_b.w_ren, 0);
        chk({tag, "_b_busy"}, bus_b.busy, 0);
        chk({tag, "_b_class"}, bus_b.out_class, 0);
        chk({tag, "_b_score"}, $signed(bus_b.out_score), 0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            w_mem[n] = {IN_WIDTH{2'b01}};
            b_mem[n] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        // All +1 weights, zero biases: equal scores, lowest class wins.
        run("all_pos", 8'hFF, 1'b0);

        // Class 0 weights flipped to -1.
        w_mem[NUM_HIDDEN*HID_WIDTH] = {IN_WIDTH{2'b11}};
        run("neg_class0", 8'hFF, 1'b0);

        // Zero weights: hidden signs come from biases, class decided by bias alone; hold result.
        for (int n = 0; n < NUM_NEURONS; n++) begin
            w_mem[n] = '0;
            b_mem[n] = -8'sd1;
        end
        b_mem[NUM_HIDDEN*HID_WIDTH]     = 8'sd3;
        b_mem[NUM_HIDDEN*HID_WIDTH + 1] = 8'sd5;
        run("bias_only", 8'h5A, 1'b1);

        // Reset during layer-0 accumulation aborts cleanly.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        rst = 1'b1;
        run("after_reset", 8'h3C, 1'b0);

        // Random networks and inputs.
        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                w_mem[n] = (2*IN_WIDTH)'($urandom);
                b_mem[n] = BIAS_W'($urandom_range(0, 255));
            end
            run($sformatf("rand%0d", t), IN_WIDTH'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
